// File: rtl/cache_read_write_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller between the
// MEM stage and a 64-bit line SRAM; freezes the pipeline while an SRAM access is pending.
module cache_read_write_controller #(
    parameter int SETS    = 64,
    parameter int INDEX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic        mem_rd_en,
    input  logic        mem_wr_en,
    output logic        ready,
    output logic [31:0] mem_rdata,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_req,
    output logic        sram_we,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    localparam int TAG_W = 29 - INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        READ_MISS,
        WRITE
    } state_t;

    state_t state_q, state_d;

    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_q   [SETS];
    logic [31:0]        word0_q [SETS];
    logic [31:0]        word1_q [SETS];

    logic               word_sel;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic [31:0]        cached_word;
    logic [31:0]        sram_word;
    logic               fill_en;
    logic               wr_hit_en;

    assign word_sel    = mem_address[2];
    assign index       = mem_address[3 +: INDEX_W];
    assign tag         = mem_address[31 : 3+INDEX_W];
    assign hit         = valid_q[index] && (tag_q[index] == tag);
    assign cached_word = word_sel ? word1_q[index] : word0_q[index];
    assign sram_word   = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
    assign sram_wdata  = mem_wdata;

    // Reset overrides every output in the same cycle so an in-flight SRAM access is dropped.
    always_comb begin
        state_d      = state_q;
        ready        = 1'b1;
        sram_req     = 1'b0;
        sram_we      = 1'b0;
        mem_rdata    = 32'h0;
        sram_address = {mem_address[31:3], 3'b000};
        fill_en      = 1'b0;
        wr_hit_en    = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (mem_wr_en) begin
                        ready     = 1'b0;
                        wr_hit_en = hit;
                        state_d   = WRITE;
                    end else if (mem_rd_en) begin
                        if (hit) begin
                            mem_rdata = cached_word;
                        end else begin
                            ready   = 1'b0;
                            state_d = READ_MISS;
                        end
                    end
                end
                READ_MISS: begin
                    sram_req = 1'b1;
                    ready    = 1'b0;
                    if (sram_ready) begin
                        ready     = 1'b1;
                        mem_rdata = sram_word;
                        fill_en   = 1'b1;
                        state_d   = IDLE;
                    end
                end
                WRITE: begin
                    sram_req     = 1'b1;
                    sram_we      = 1'b1;
                    sram_address = mem_address;
                    ready        = 1'b0;
                    if (sram_ready) begin
                        ready   = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (fill_en) begin
                valid_q[index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[index]   <= tag;
            word0_q[index] <= sram_rdata[31:0];
            word1_q[index] <= sram_rdata[63:32];
        end else if (wr_hit_en) begin
            if (word_sel) begin
                word1_q[index] <= mem_wdata;
            end else begin
                word0_q[index] <= mem_wdata;
            end
        end
    end

endmodule

// File: tb/tb_cache_read_write_controller.sv
// Scoreboard bench for cache_read_write_controller: stimulus pushes expected completions,
// a negedge monitor pops and compares them whenever an access completes.
module tb_cache_read_write_controller;

    logic        clk;
    logic        rst;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic        ready;
    logic [31:0] mem_rdata;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_req;
    logic        sram_we;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    cache_read_write_controller #(.SETS(64), .INDEX_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .ready        (ready),
        .mem_rdata    (mem_rdata),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_req     (sram_req),
        .sram_we      (sram_we),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        sram;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // SRAM model controls
    bit   sram_auto = 1'b1;
    bit   sram_tie  = 1'b0;
    int   sram_lat  = 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // SRAM responder: answers after sram_lat cycles of sram_req, or always when tied high
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (sram_tie) begin
                sram_ready = 1'b1;
            end else if (sram_auto) begin
                if (sram_req) begin
                    if (cnt >= sram_lat - 1) begin
                        sram_ready = 1'b1;
                        cnt = 0;
                    end else begin
                        sram_ready = 1'b0;
                        cnt++;
                    end
                end else begin
                    sram_ready = 1'b0;
                    cnt = 0;
                end
            end
        end
    end

    // Monitor: one pop per completed access
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (mem_rd_en || mem_wr_en) && ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_completion: got addr %h expected none", mem_address);
                end else begin
                    e = sb_q.pop_front();
                    chk("mem_rdata", {32'h0, mem_rdata}, {32'h0, e.rdata});
                    chk("sram_req", {63'h0, sram_req}, {63'h0, e.sram});
                    if (e.sram) begin
                        chk("sram_address", {32'h0, sram_address}, {32'h0, e.addr});
                        chk("sram_we", {63'h0, sram_we}, {63'h0, e.we});
                        if (e.we) begin
                            chk("sram_wdata", {32'h0, sram_wdata}, {32'h0, e.wdata});
                        end
                    end
                end
            end
        end
    end

    // Issue one access (called at posedge+1); exp_cycles=0 skips the latency check
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [63:0] line, input int lat,
                          input logic [31:0] exp_rd, input logic exp_sram,
                          input logic [31:0] exp_addr, input logic exp_we, input int exp_cycles);
        exp_t e;
        int   cycles;
        e.rdata = exp_rd;
        e.sram  = exp_sram;
        e.addr  = exp_addr;
        e.we    = exp_we;
        e.wdata = wdata;
        sb_q.push_back(e);
        sram_rdata  = line;
        sram_lat    = lat;
        mem_address = addr;
        mem_wdata   = wdata;
        mem_rd_en   = rd;
        mem_wr_en   = wr;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!ready && cycles < 50);
        if (!ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got ready %b after %0d cycles expected 1", ready, cycles);
        end
        if (exp_cycles > 0) begin
            chk("latency", 64'(cycles), 64'(exp_cycles));
        end
        $display("txn rd=%0d wr=%0d addr=%h wdata=%h rdata=%h cycles=%0d",
                 rd, wr, addr, wdata, mem_rdata, cycles);
        @(posedge clk);
        #1;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        mem_address = 32'h0;
        mem_wdata   = 32'h0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        sram_rdata  = 64'h0;
        sram_ready  = 1'b0;

        // reset state, during and after reset
        @(negedge clk);
        chk("rst_ready", {63'h0, ready}, 64'h1);
        chk("rst_sram_req", {63'h0, sram_req}, 64'h0);
        chk("rst_sram_we", {63'h0, sram_we}, 64'h0);
        chk("rst_mem_rdata", {32'h0, mem_rdata}, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {63'h0, ready}, 64'h1);
        chk("post_rst_sram_req", {63'h0, sram_req}, 64'h0);
        @(posedge clk);
        #1;

        // 1: cold miss with 3 wait cycles, then hit on the other word
        access(1, 0, 32'h40, 32'h0, 64'h1111_2222_3333_4444, 4, 32'h3333_4444, 1, 32'h40, 0, 5);
        access(1, 0, 32'h44, 32'h0, 64'h0, 1, 32'h1111_2222, 0, 32'h0, 0, 1);

        // 2: store hit is written through and updates the cached word
        access(0, 1, 32'h44, 32'hDEAD_BEEF, 64'h0, 2, 32'h0, 1, 32'h44, 1, 3);
        access(1, 0, 32'h44, 32'h0, 64'h0, 1, 32'hDEAD_BEEF, 0, 32'h0, 0, 1);
        access(1, 0, 32'h40, 32'h0, 64'h0, 1, 32'h3333_4444, 0, 32'h0, 0, 1);

        // 3: conflict on index 8 evicts, original line misses again
        access(1, 0, 32'h240, 32'h0, 64'hAAAA_0001_BBBB_0002, 1, 32'hBBBB_0002, 1, 32'h240, 0, 2);
        access(1, 0, 32'h244, 32'h0, 64'h0, 1, 32'hAAAA_0001, 0, 32'h0, 0, 1);
        access(1, 0, 32'h40, 32'h0, 64'h5555_6666_7777_8888, 3, 32'h7777_8888, 1, 32'h40, 0, 4);
        access(1, 0, 32'h44, 32'h0, 64'h0, 1, 32'h5555_6666, 0, 32'h0, 0, 1);

        // 4: store miss does not allocate
        access(0, 1, 32'h80, 32'h0BAD_F00D, 64'h0, 2, 32'h0, 1, 32'h80, 1, 3);
        access(1, 0, 32'h80, 32'h0, 64'h0000_0009_0000_0008, 1, 32'h0000_0008, 1, 32'h80, 0, 2);

        // 5: reset in the middle of a read miss
        sram_auto   = 1'b0;
        sram_ready  = 1'b0;
        mem_address = 32'h240;
        mem_rd_en   = 1'b1;
        @(negedge clk);
        chk("t5_detect_ready", {63'h0, ready}, 64'h0);
        @(negedge clk);
        chk("t5_miss_sram_req", {63'h0, sram_req}, 64'h1);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        mem_rd_en = 1'b0;
        @(negedge clk);
        chk("t5_rst_sram_req", {63'h0, sram_req}, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_after_ready", {63'h0, ready}, 64'h1);
        chk("t5_after_sram_req", {63'h0, sram_req}, 64'h0);
        @(posedge clk);
        #1;
        sram_ready = 1'b1;
        sram_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        chk("t5_late_ready", {63'h0, ready}, 64'h1);
        chk("t5_late_sram_req", {63'h0, sram_req}, 64'h0);
        @(posedge clk);
        #1;
        sram_ready = 1'b0;
        sram_auto  = 1'b1;
        access(1, 0, 32'h44, 32'h0, 64'hCAFE_0044_CAFE_0040, 2, 32'hCAFE_0044, 1, 32'h40, 0, 3);

        // 6: zero-wait SRAM, simultaneous rd+wr acts as a write
        sram_tie = 1'b1;
        access(1, 0, 32'h300, 32'h0, 64'h0102_0304_0506_0708, 1, 32'h0506_0708, 1, 32'h300, 0, 2);
        access(1, 1, 32'h304, 32'h7777_AAAA, 64'h0, 1, 32'h0, 1, 32'h304, 1, 2);
        access(1, 0, 32'h304, 32'h0, 64'h0, 1, 32'h7777_AAAA, 0, 32'h0, 0, 1);
        access(1, 0, 32'h300, 32'h0, 64'h0, 1, 32'h0506_0708, 0, 32'h0, 0, 1);
        sram_tie = 1'b0;

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
